dmem_ctrl: RTL and testbench

- Handshaked RV32 data-memory controller that replaces the bare word array with byte-enabled storage.
- Decodes funct3 to perform LB/LH/LW/LBU/LHU/SB/SH/SW.
- Generates byte lanes and aligns store data.
- Sign- or zero-extends load data.
- Flags misaligned, out-of-range and illegal accesses.
- Inserts a parametrised number of wait states so the core's LSU can be tested against slow memory.
- Sits between the core's load/store unit and the on-chip data RAM.

---
 rtl/dmem_pkg.sv | 20 ++
 rtl/dmem_if.sv | 24 ++
 rtl/dmem_align.sv | 69 ++++++
 rtl/dmem_ctrl.sv | 155 +++++++++++++++
 tb/tb_dmem_ctrl.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared constants and types for the RV32 data-memory controller.
package dmem_pkg;

    // RV32 load/store funct3 encodings
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Width of the wait-state down-counter (covers 0..15 wait states)
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_if.sv
// Request/response bus between the core LSU (master) and the data-memory controller (slave).
interface dmem_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_align.sv
// Combinational lane logic: store byte enables and data replication, load
// shift and sign/zero extension, plus misalignment and illegal-funct3 flags.
module dmem_align
    import dmem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic        we,
    input  logic [1:0]  lane,
    input  logic [31:0] wdata,
    input  logic [31:0] raw,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_al,
    output logic [31:0] rdata_ext,
    output logic        misalign,
    output logic        illegal
);

    logic [31:0] shifted;
    logic        is_half;
    logic        is_word;

    // Decode access size, faults and lane placement for the current request
    always_comb begin
        byte_en   = 4'b0000;
        wdata_al  = 32'h0;
        rdata_ext = 32'h0;
        shifted   = raw >> {lane, 3'b000};

        // Low two funct3 bits give the size for both loads and stores
        is_half  = (funct3[1:0] == 2'b01);
        is_word  = (funct3[1:0] == 2'b10);
        misalign = (is_half && lane[0]) || (is_word && (lane != 2'b00));

        if (we) begin
            illegal = (funct3 >= 3'd3);
        end else begin
            illegal = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
        end

        case (funct3)
            F3_B: begin
                byte_en  = 4'b0001 << lane;
                wdata_al = {4{wdata[7:0]}};
            end
            F3_H: begin
                byte_en  = 4'b0011 << lane;
                wdata_al = {2{wdata[15:0]}};
            end
            F3_W: begin
                byte_en  = 4'b1111;
                wdata_al = wdata;
            end
            default: begin
                byte_en  = 4'b0000;
                wdata_al = 32'h0;
            end
        endcase

        case (funct3)
            F3_B:    rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   rdata_ext = {24'h0, shifted[7:0]};
            F3_H:    rdata_ext = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   rdata_ext = {16'h0, shifted[15:0]};
            F3_W:    rdata_ext = shifted;
            default: rdata_ext = 32'h0;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Handshaked RV32 data-memory controller with byte-enabled storage and
// a configurable number of wait states between accept and access.
//
// state | meaning
// IDLE  | ready for a request; accept captures the request fields
// WAIT  | counting down the wait states, inputs ignored
// RESP  | one-cycle response pulse, then back to IDLE
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int ADDR_W      = 32,
    parameter int WAIT_STATES = 0,
    parameter int INIT_ZERO   = 1
) (
    input  logic  clk,
    input  logic  rst,
    dmem_if.slave bus
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam bit NO_WAIT = (WAIT_STATES == 0);
    localparam logic [CNT_W-1:0] CNT_INIT = (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;
    localparam logic [ADDR_W-3:0] DEPTH_IDX = (ADDR_W-2)'(DEPTH);
    localparam logic [31:0] INIT_WORD = (INIT_ZERO != 0) ? 32'h0 : 32'hxxxx_xxxx;

    logic [31:0] mem [DEPTH] = '{default: INIT_WORD};

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               cap_we;
    logic [2:0]         cap_funct3;
    logic [ADDR_W-1:0]  cap_addr;
    logic [31:0]        cap_wdata;

    logic               acc_we;
    logic [2:0]         acc_funct3;
    logic [ADDR_W-1:0]  acc_addr;
    logic [31:0]        acc_wdata;
    logic [ADDR_W-3:0]  word_idx;
    logic [IDX_W-1:0]   mem_idx;
    logic [31:0]        raw;
    logic               out_of_range;
    logic               access_err;
    logic               commit;
    logic               mem_we;

    logic [3:0]         byte_en;
    logic [31:0]        wdata_al;
    logic [31:0]        rdata_ext;
    logic               misalign;
    logic               illegal;

    // With zero wait states the access happens on the accept edge itself,
    // so the live inputs feed the datapath while IDLE.
    always_comb begin
        if (state == IDLE) begin
            acc_we     = bus.req_we;
            acc_funct3 = bus.req_funct3;
            acc_addr   = bus.req_addr;
            acc_wdata  = bus.req_wdata;
        end else begin
            acc_we     = cap_we;
            acc_funct3 = cap_funct3;
            acc_addr   = cap_addr;
            acc_wdata  = cap_wdata;
        end
        word_idx     = acc_addr[ADDR_W-1:2];
        mem_idx      = word_idx[IDX_W-1:0];
        out_of_range = (word_idx >= DEPTH_IDX);
        raw          = mem[mem_idx];
        access_err   = misalign || illegal || out_of_range;
        commit       = ((state == IDLE) && bus.req_valid && NO_WAIT) ||
                       ((state == WAIT) && (cnt == '0));
        mem_we       = commit && !rst && acc_we && !access_err;
    end

    dmem_align u_align (
        .funct3    (acc_funct3),
        .we        (acc_we),
        .lane      (acc_addr[1:0]),
        .wdata     (acc_wdata),
        .raw       (raw),
        .byte_en   (byte_en),
        .wdata_al  (wdata_al),
        .rdata_ext (rdata_ext),
        .misalign  (misalign),
        .illegal   (illegal)
    );

    // Request FSM with registered handshake and response outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            cap_we        <= 1'b0;
            cap_funct3    <= 3'b000;
            cap_addr      <= '0;
            cap_wdata     <= 32'h0;
            bus.req_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_err   <= 1'b0;
            bus.rsp_rdata <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        cap_we        <= bus.req_we;
                        cap_funct3    <= bus.req_funct3;
                        cap_addr      <= bus.req_addr;
                        cap_wdata     <= bus.req_wdata;
                        bus.req_ready <= 1'b0;
                        if (NO_WAIT) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    state         <= IDLE;
                    bus.req_ready <= 1'b1;
                end
                default: begin
                    state         <= IDLE;
                    bus.req_ready <= 1'b1;
                end
            endcase

            bus.rsp_valid <= commit;
            if (commit) begin
                bus.rsp_err   <= access_err;
                bus.rsp_rdata <= (access_err || acc_we) ? 32'h0 : rdata_ext;
            end
        end
    end

    // Byte-enabled array write; reset blocks a write on a coinciding edge
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (mem_we && byte_en[i]) begin
                mem[mem_idx][8*i +: 8] <= wdata_al[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: one instance with no wait states and one
// with three wait states, each on its own bus and reset.
module tb_dmem_ctrl;
    import dmem_pkg::*;

    logic clk = 1'b0;
    logic rst0;
    logic rst3;

    always #5 clk = ~clk;

    dmem_if #(.ADDR_W(32)) bus0 ();
    dmem_if #(.ADDR_W(32)) bus3 ();

    dmem_ctrl #(.DEPTH(1024), .ADDR_W(32), .WAIT_STATES(0), .INIT_ZERO(1)) dut0 (
        .clk (clk),
        .rst (rst0),
        .bus (bus0)
    );

    dmem_ctrl #(.DEPTH(1024), .ADDR_W(32), .WAIT_STATES(3), .INIT_ZERO(1)) dut3 (
        .clk (clk),
        .rst (rst3),
        .bus (bus3)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int sel, input logic v, input logic we, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd);
        if (sel == 0) begin
            bus0.req_valid = v; bus0.req_we = we; bus0.req_funct3 = f3;
            bus0.req_addr = a; bus0.req_wdata = wd;
        end else begin
            bus3.req_valid = v; bus3.req_we = we; bus3.req_funct3 = f3;
            bus3.req_addr = a; bus3.req_wdata = wd;
        end
    endtask

    function automatic logic get_valid(input int sel);
        return (sel == 0) ? bus0.rsp_valid : bus3.rsp_valid;
    endfunction

    function automatic logic get_ready(input int sel);
        return (sel == 0) ? bus0.req_ready : bus3.req_ready;
    endfunction

    function automatic logic [31:0] get_rdata(input int sel);
        return (sel == 0) ? bus0.rsp_rdata : bus3.rsp_rdata;
    endfunction

    function automatic logic get_err(input int sel);
        return (sel == 0) ? bus0.rsp_err : bus3.rsp_err;
    endfunction

    // One full transaction starting at a negedge with the DUT in IDLE
    task automatic xact(input string tag, input int sel, input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
        int lat;
        set_req(sel, 1'b1, we, f3, a, wd);
        @(negedge clk);
        set_req(sel, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        check({tag, ".busy"}, 32'(get_ready(sel)), 32'd0);
        lat = 1;
        while (!get_valid(sel) && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
        check({tag, ".rdata"}, get_rdata(sel), exp_rd);
        check({tag, ".err"}, 32'(get_err(sel)), 32'(exp_err));
        @(negedge clk);
        check({tag, ".pulse"}, 32'(get_valid(sel)), 32'd0);
        check({tag, ".ready"}, 32'(get_ready(sel)), 32'd1);
    endtask

    initial begin
        logic seen;
        rst0 = 1'b1;
        rst3 = 1'b1;
        set_req(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        set_req(3, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        repeat (3) @(negedge clk);
        rst0 = 1'b0;
        rst3 = 1'b0;

        check("rst0.ready", 32'(bus0.req_ready), 32'd1);
        check("rst0.valid", 32'(bus0.rsp_valid), 32'd0);
        check("rst0.rdata", bus0.rsp_rdata, 32'h0);
        check("rst0.err",   32'(bus0.rsp_err), 32'd0);
        check("rst3.ready", 32'(bus3.req_ready), 32'd1);
        check("rst3.valid", 32'(bus3.rsp_valid), 32'd0);

        // No wait states: basic store/load
        xact("sw10", 0, 1'b1, F3_W, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1);
        xact("lw10", 0, 1'b0, F3_W, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1);

        // Byte lanes
        xact("sw20", 0, 1'b1, F3_W, 32'h20, 32'h00000000, 32'h0, 1'b0, 1);
        xact("sb23", 0, 1'b1, F3_B, 32'h23, 32'h00000080, 32'h0, 1'b0, 1);
        xact("sh20", 0, 1'b1, F3_H, 32'h20, 32'h0000A5A5, 32'h0, 1'b0, 1);
        xact("lw20",  0, 1'b0, F3_W,  32'h20, 32'h0, 32'h8000A5A5, 1'b0, 1);
        xact("lb23",  0, 1'b0, F3_B,  32'h23, 32'h0, 32'hFFFFFF80, 1'b0, 1);
        xact("lbu23", 0, 1'b0, F3_BU, 32'h23, 32'h0, 32'h00000080, 1'b0, 1);
        xact("lh20",  0, 1'b0, F3_H,  32'h20, 32'h0, 32'hFFFFA5A5, 1'b0, 1);
        xact("lhu22", 0, 1'b0, F3_HU, 32'h22, 32'h0, 32'h00008000, 1'b0, 1);

        // Faults
        xact("lw21",   0, 1'b0, F3_W,  32'h21, 32'h0, 32'h0, 1'b1, 1);
        xact("sh13",   0, 1'b1, F3_H,  32'h13, 32'h0000BEEF, 32'h0, 1'b1, 1);
        xact("lw10b",  0, 1'b0, F3_W,  32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1);
        xact("lwoor",  0, 1'b0, F3_W,  32'h1000, 32'h0, 32'h0, 1'b1, 1);
        xact("ldf3_3", 0, 1'b0, 3'd3,  32'h10, 32'h0, 32'h0, 1'b1, 1);
        xact("stf3_3", 0, 1'b1, 3'd3,  32'h10, 32'h11111111, 32'h0, 1'b1, 1);
        xact("lw10c",  0, 1'b0, F3_W,  32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1);
        xact("lh21",   0, 1'b0, F3_H,  32'h21, 32'h0, 32'h0, 1'b1, 1);

        // Last in-range byte
        xact("sbtop",  0, 1'b1, F3_B,  32'hFFF, 32'h0000007E, 32'h0, 1'b0, 1);
        xact("lbutop", 0, 1'b0, F3_BU, 32'hFFF, 32'h0, 32'h0000007E, 1'b0, 1);
        xact("lwtop",  0, 1'b0, F3_W,  32'hFFC, 32'h0, 32'h7E000000, 1'b0, 1);

        // Three wait states
        xact("w3sw10", 3, 1'b1, F3_W, 32'h10, 32'h11223344, 32'h0, 1'b0, 4);

        // Held valid with changing address: accepts at cycles 0 and 5 only
        set_req(3, 1'b1, 1'b0, F3_W, 32'h10, 32'h0);
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            check($sformatf("hold.valid.c%0d", c), 32'(bus3.rsp_valid),
                  ((c == 4) || (c == 9)) ? 32'd1 : 32'd0);
            check($sformatf("hold.ready.c%0d", c), 32'(bus3.req_ready),
                  (c == 5) ? 32'd1 : 32'd0);
            if (c == 4 || c == 9) begin
                check($sformatf("hold.rdata.c%0d", c), bus3.rsp_rdata, 32'h11223344);
            end
            if (c < 5) begin
                bus3.req_addr = 32'h20 + 32'(c) * 32'd4;
            end else if (c == 5) begin
                bus3.req_addr = 32'h10;
            end else if (c < 9) begin
                bus3.req_addr = 32'h30 + 32'(c) * 32'd4;
            end else begin
                set_req(3, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
            end
        end
        @(negedge clk);
        check("hold.idle", 32'(bus3.req_ready), 32'd1);

        // Reset while waiting: request dropped, no write
        set_req(3, 1'b1, 1'b1, F3_W, 32'h40, 32'h12345678);
        @(negedge clk);
        set_req(3, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        @(negedge clk);
        rst3 = 1'b1;
        @(negedge clk);
        rst3 = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            if (bus3.rsp_valid) seen = 1'b1;
            @(negedge clk);
        end
        check("rstmid.novalid", 32'(seen), 32'd0);
        check("rstmid.ready", 32'(bus3.req_ready), 32'd1);
        xact("rstmid.lw40", 3, 1'b0, F3_W, 32'h40, 32'h0, 32'h0, 1'b0, 4);

        // Reset exactly on the commit edge of a store
        set_req(3, 1'b1, 1'b1, F3_W, 32'h40, 32'hCAFEF00D);
        @(negedge clk);
        set_req(3, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst3 = 1'b1;
        @(negedge clk);
        rst3 = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            if (bus3.rsp_valid) seen = 1'b1;
            @(negedge clk);
        end
        check("rstcommit.novalid", 32'(seen), 32'd0);
        xact("rstcommit.lw40", 3, 1'b0, F3_W, 32'h40, 32'h0, 32'h0, 1'b0, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
